// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the PC control block: condition codes, flag bit positions,
// branch-history counter encodings and the counter saturation helper.
package pc_ctrl_pkg;

    localparam logic [2:0] COND_NE     = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_OV     = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    localparam logic [1:0] CNT_RESET = WNT;

    // Move one step toward the resolved outcome, sticking at both ends.
    function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != ST)
            nxt = cnt + 2'd1;
        else if (!taken && cnt != SNT)
            nxt = cnt - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/pc_cond_eval.sv
// Combinational branch condition evaluator: maps a 3-bit condition code and
// the {V,Z,N} flags to a taken decision.
module pc_cond_eval
    import pc_ctrl_pkg::*;
(
    input  logic [2:0] d_cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic n_f, z_f, v_f;

    assign n_f = flags[FLAG_N];
    assign z_f = flags[FLAG_Z];
    assign v_f = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (d_cond)
            COND_NE:     taken = ~z_f;
            COND_EQ:     taken = z_f;
            COND_GT:     taken = ~z_f & ~n_f;
            COND_LT:     taken = n_f;
            COND_GE:     taken = z_f | (~z_f & ~n_f);
            COND_LE:     taken = n_f | z_f;
            COND_OV:     taken = v_f;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_control_bp.sv
// PC register and next-fetch-address generator with decode-stage branch resolution.
// Define PC_CTRL_BHT_EN for a 2-bit counter predictor; otherwise branches are static not-taken.
module pc_control_bp
    import pc_ctrl_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int OFF_W     = 9,
    parameter int BHT_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              f_is_br,
    input  logic              f_is_hlt,
    input  logic [OFF_W-1:0]  f_imm,
    input  logic              d_is_br,
    input  logic              d_is_br_reg,
    input  logic [2:0]        d_cond,
    input  logic [OFF_W-1:0]  d_imm,
    input  logic [DATA_W-1:0] d_reg_addr,
    input  logic [DATA_W-1:0] d_pc,
    input  logic              d_pred_taken,
    input  logic [2:0]        flags,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] pc_plus2,
    output logic              f_pred_taken,
    output logic              flush,
    output logic              halted
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(2);

    // Sign-extended word offset converted to a byte offset.
    function automatic logic [DATA_W-1:0] byte_off(input logic [OFF_W-1:0] imm);
        logic [DATA_W-1:0] ext;
        ext = {{(DATA_W-OFF_W){imm[OFF_W-1]}}, imm};
        return {ext[DATA_W-2:0], 1'b0};
    endfunction

    logic [DATA_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] f_tgt, d_seq, d_tgt, redirect;
    logic              cond_taken, flush_c, b_resolve, pred_bit;

    assign f_tgt = pc_q + PC_STEP + byte_off(f_imm);
    assign d_seq = d_pc + PC_STEP;
    assign d_tgt = d_seq + byte_off(d_imm);

    pc_cond_eval u_cond (
        .d_cond (d_cond),
        .flags  (flags),
        .taken  (cond_taken)
    );

`ifdef PC_CTRL_BHT_EN
    logic [1:0]       cnt_q [BHT_DEPTH];
    logic [IDX_W-1:0] idx_f, idx_d;

    assign idx_f    = pc_q[IDX_W:1];
    assign idx_d    = d_pc[IDX_W:1];
    assign pred_bit = cnt_q[idx_f][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                cnt_q[i] <= CNT_RESET;
        end else if (b_resolve) begin
            cnt_q[idx_d] <= cnt_step(cnt_q[idx_d], cond_taken);
        end
    end
`else
    logic unused_pred;
    assign unused_pred = d_pred_taken;
    assign pred_bit    = 1'b0;
`endif

    // Decode-stage resolution; a BR wins if both branch kinds are flagged.
    always_comb begin
        flush_c   = 1'b0;
        b_resolve = 1'b0;
        redirect  = d_seq;
        if (!rst && !stall) begin
            if (d_is_br_reg) begin
                flush_c  = cond_taken;
                redirect = d_reg_addr;
            end else if (d_is_br) begin
                b_resolve = 1'b1;
                redirect  = cond_taken ? d_tgt : d_seq;
`ifdef PC_CTRL_BHT_EN
                flush_c   = cond_taken != d_pred_taken;
`else
                flush_c   = cond_taken;
`endif
            end
        end
    end

    assign f_pred_taken = ~rst & f_is_br & ~halted_q & pred_bit;

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (stall) begin
            pc_d = pc_q;
        end else if (flush_c) begin
            pc_d     = redirect;
            halted_d = 1'b0;
        end else if (halted_q) begin
            pc_d = pc_q;
        end else if (f_is_hlt) begin
            halted_d = 1'b1;
        end else if (f_pred_taken) begin
            pc_d = f_tgt;
        end else begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    assign pc_out   = pc_q;
    assign pc_plus2 = pc_q + PC_STEP;
    assign flush    = flush_c;
    assign halted   = halted_q;

endmodule

// File: tb/tb_pc_control_bp.sv
// Scoreboard bench for pc_control_bp: a cycle model pushes expected outputs each
// cycle, which are popped and compared against the DUT at the falling edge.
module tb_pc_control_bp;

    logic        clk = 1'b0;
    logic        rst, stall, f_is_br, f_is_hlt, d_is_br, d_is_br_reg, d_pred_taken;
    logic [8:0]  f_imm, d_imm;
    logic [2:0]  d_cond, flags;
    logic [15:0] d_reg_addr, d_pc;
    logic [15:0] pc_out, pc_plus2;
    logic        f_pred_taken, flush, halted;

    always #5 clk = ~clk;

    pc_control_bp #(.DATA_W(16), .OFF_W(9), .BHT_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .f_is_br(f_is_br), .f_is_hlt(f_is_hlt),
        .f_imm(f_imm), .d_is_br(d_is_br), .d_is_br_reg(d_is_br_reg), .d_cond(d_cond),
        .d_imm(d_imm), .d_reg_addr(d_reg_addr), .d_pc(d_pc), .d_pred_taken(d_pred_taken),
        .flags(flags), .pc_out(pc_out), .pc_plus2(pc_plus2), .f_pred_taken(f_pred_taken),
        .flush(flush), .halted(halted)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] pc2;
        logic        pred;
        logic        flush;
        logic        halt;
    } exp_t;

    exp_t        sbq[$];
    int unsigned vecs = 0;
    int unsigned errs = 0;

    logic [15:0] m_pc;
    logic        m_halt;
    logic        m_known = 1'b0;
    logic [1:0]  m_cnt [8];
    logic        last_pred, obs_flush;

    function automatic logic m_cond(input logic [2:0] c, input logic [2:0] f);
        logic n, z, v;
        n = f[0]; z = f[1]; v = f[2];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] m_off(input logic [8:0] imm);
        logic signed [15:0] s;
        s = $signed(imm);
        return s * 16'sd2;
    endfunction

    task automatic set_idle();
        rst = 0; stall = 0; f_is_br = 0; f_is_hlt = 0; f_imm = '0;
        d_is_br = 0; d_is_br_reg = 0; d_cond = '0; d_imm = '0;
        d_reg_addr = '0; d_pc = '0; d_pred_taken = 0; flags = '0;
    endtask

    // One clock: model expectation pushed, popped and compared, then the model steps.
    task automatic cycle();
        exp_t e, g;
        logic tk, fl, bres, nh;
        logic [15:0] red, np;
        logic [2:0]  ix;
        @(negedge clk);
        ix = m_pc[3:1];
        e.pc  = m_pc;
        e.pc2 = m_pc + 16'd2;
        e.halt = m_halt;
`ifdef PC_CTRL_BHT_EN
        e.pred = !rst && f_is_br && !m_halt && m_cnt[ix][1];
`else
        e.pred = 1'b0;
`endif
        tk = m_cond(d_cond, flags);
        fl = 0; bres = 0; red = d_pc + 16'd2;
        if (!rst && !stall) begin
            if (d_is_br_reg) begin
                fl = tk; red = d_reg_addr;
            end else if (d_is_br) begin
                bres = 1;
                red = tk ? d_pc + 16'd2 + m_off(d_imm) : d_pc + 16'd2;
`ifdef PC_CTRL_BHT_EN
                fl = (tk != d_pred_taken);
`else
                fl = tk;
`endif
            end
        end
        e.flush = fl;
        sbq.push_back(e);

        g = sbq.pop_front();
        last_pred = g.pred;
        obs_flush = flush;
        vecs++;
        if (f_pred_taken !== g.pred) begin
            errs++; $display("FAIL pred: got %b want %b at %0t", f_pred_taken, g.pred, $time);
        end
        vecs++;
        if (flush !== g.flush) begin
            errs++; $display("FAIL flush: got %b want %b at %0t", flush, g.flush, $time);
        end
        if (m_known) begin
            vecs++;
            if (pc_out !== g.pc) begin
                errs++; $display("FAIL pc_out: got %h want %h at %0t", pc_out, g.pc, $time);
            end
            vecs++;
            if (pc_plus2 !== g.pc2) begin
                errs++; $display("FAIL pc_plus2: got %h want %h at %0t", pc_plus2, g.pc2, $time);
            end
            vecs++;
            if (halted !== g.halt) begin
                errs++; $display("FAIL halted: got %b want %b at %0t", halted, g.halt, $time);
            end
        end

        np = m_pc; nh = m_halt;
        if (stall) np = m_pc;
        else if (fl) begin np = red; nh = 0; end
        else if (m_halt) np = m_pc;
        else if (f_is_hlt) nh = 1;
        else if (e.pred) np = m_pc + 16'd2 + m_off(f_imm);
        else np = m_pc + 16'd2;

        @(posedge clk);
        if (rst) begin
            m_pc = 0; m_halt = 0; m_known = 1;
            for (int i = 0; i < 8; i++) m_cnt[i] = 2'b01;
        end else begin
            m_pc = np; m_halt = nh;
            if (bres) begin
                if (tk && m_cnt[d_pc[3:1]] != 2'b11) m_cnt[d_pc[3:1]] = m_cnt[d_pc[3:1]] + 2'd1;
                else if (!tk && m_cnt[d_pc[3:1]] != 2'b00) m_cnt[d_pc[3:1]] = m_cnt[d_pc[3:1]] - 2'd1;
            end
        end
        #1;
    endtask

    task automatic redirect_to(input logic [15:0] a);
        set_idle();
        d_is_br_reg = 1; d_cond = 3'b111; d_reg_addr = a;
        cycle();
        set_idle();
        vecs++;
        if (pc_out !== a) begin
            errs++; $display("FAIL redirect: got %h want %h", pc_out, a);
        end
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1; f_is_br = 1; d_is_br_reg = 1; d_cond = 3'b111; d_reg_addr = 16'h5555;
        cycle();
        cycle();
        set_idle();
        vecs++;
        if (pc_out !== 16'h0000 || halted !== 1'b0) begin
            errs++; $display("FAIL reset: got pc %h halted %b want 0000 0", pc_out, halted);
        end
    endtask

    task automatic test_sequential();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            vecs++;
            if (pc_out !== 16'(2 * (i + 1)) || obs_flush !== 1'b0) begin
                errs++; $display("FAIL seq: got pc %h flush %b want %h 0", pc_out, obs_flush, 16'(2 * (i + 1)));
            end
        end
    endtask

    task automatic test_b_eq();
        redirect_to(16'h0010);
        f_is_br = 1; f_imm = 9'd4;
        cycle();
        set_idle();
        d_is_br = 1; d_pc = 16'h0010; d_cond = 3'b001; d_imm = 9'd4; flags = 3'b010;
        d_pred_taken = last_pred;
        cycle();
        vecs++;
        if (obs_flush !== 1'b1 || pc_out !== 16'h001A) begin
            errs++; $display("FAIL beq1: got flush %b pc %h want 1 001a", obs_flush, pc_out);
        end
        redirect_to(16'h0010);
        f_is_br = 1; f_imm = 9'd4;
        cycle();
        vecs++;
`ifdef PC_CTRL_BHT_EN
        if (last_pred !== 1'b1 || pc_out !== 16'h001A) begin
            errs++; $display("FAIL beq2 fetch: got pc %h want 001a", pc_out);
        end
`else
        if (pc_out !== 16'h0012) begin
            errs++; $display("FAIL beq2 fetch: got pc %h want 0012", pc_out);
        end
`endif
        set_idle();
        d_is_br = 1; d_pc = 16'h0010; d_cond = 3'b001; d_imm = 9'd4; flags = 3'b010;
        d_pred_taken = last_pred;
        cycle();
        vecs++;
`ifdef PC_CTRL_BHT_EN
        if (obs_flush !== 1'b0 || pc_out !== 16'h001C) begin
            errs++; $display("FAIL beq2 dec: got flush %b pc %h want 0 001c", obs_flush, pc_out);
        end
`else
        if (obs_flush !== 1'b1 || pc_out !== 16'h001A) begin
            errs++; $display("FAIL beq2 dec: got flush %b pc %h want 1 001a", obs_flush, pc_out);
        end
`endif
    endtask

    task automatic test_b_gt();
        redirect_to(16'h0020);
        f_is_br = 1; f_imm = 9'h1FD;
        cycle();
        set_idle();
        d_is_br = 1; d_pc = 16'h0020; d_cond = 3'b010; d_imm = 9'h1FD; flags = 3'b001;
        d_pred_taken = last_pred;
        cycle();
        vecs++;
`ifdef PC_CTRL_BHT_EN
        if (obs_flush !== 1'b1 || pc_out !== 16'h0022) begin
            errs++; $display("FAIL bgt: got flush %b pc %h want 1 0022", obs_flush, pc_out);
        end
`else
        if (obs_flush !== 1'b0 || pc_out !== 16'h0024) begin
            errs++; $display("FAIL bgt: got flush %b pc %h want 0 0024", obs_flush, pc_out);
        end
`endif
        redirect_to(16'h0020);
        f_is_br = 1; f_imm = 9'h1FD;
        cycle();
        set_idle();
    endtask

    task automatic test_br_hlt();
        set_idle();
        d_is_br_reg = 1; d_cond = 3'b111; d_reg_addr = 16'h1234; f_is_hlt = 1;
        cycle();
        set_idle();
        vecs++;
        if (obs_flush !== 1'b1 || pc_out !== 16'h1234 || halted !== 1'b0) begin
            errs++; $display("FAIL br_hlt: got flush %b pc %h halted %b want 1 1234 0", obs_flush, pc_out, halted);
        end
    endtask

    task automatic test_hlt();
        redirect_to(16'h0040);
        f_is_hlt = 1;
        cycle();
        set_idle();
        f_is_br = 1; f_imm = 9'd4;
        for (int i = 0; i < 5; i++) begin
            cycle();
            vecs++;
            if (pc_out !== 16'h0040 || halted !== 1'b1) begin
                errs++; $display("FAIL hlt hold: got pc %h halted %b want 0040 1", pc_out, halted);
            end
        end
        set_idle();
        rst = 1;
        cycle();
        set_idle();
        vecs++;
        if (pc_out !== 16'h0000 || halted !== 1'b0) begin
            errs++; $display("FAIL hlt reset: got pc %h halted %b want 0000 0", pc_out, halted);
        end
    endtask

    task automatic test_stall();
        logic [15:0] held;
        set_idle();
        stall = 1; f_is_br = 1; d_is_br = 1; d_pc = 16'h0030; d_cond = 3'b001;
        d_imm = 9'd2; flags = 3'b010;
        held = m_pc;
        cycle(); cycle();
        vecs++;
        if (pc_out !== held || obs_flush !== 1'b0) begin
            errs++; $display("FAIL stall hold: got pc %h flush %b want %h 0", pc_out, obs_flush, held);
        end
        set_idle();
        cycle();
        redirect_to(16'h0030);
        f_is_br = 1; f_imm = 9'd2;
        cycle();
        vecs++;
        if (last_pred !== 1'b0 || pc_out !== 16'h0032) begin
            errs++; $display("FAIL stall cnt: got pc %h want 0032", pc_out);
        end
        set_idle();
        stall = 1; d_is_br = 1; d_pc = 16'h0030; d_cond = 3'b001; d_imm = 9'd2; flags = 3'b010;
        held = m_pc;
        cycle(); cycle();
        vecs++;
        if (pc_out !== held || obs_flush !== 1'b0) begin
            errs++; $display("FAIL stall hold2: got pc %h flush %b want %h 0", pc_out, obs_flush, held);
        end
        stall = 0;
        cycle();
        set_idle();
        vecs++;
        if (obs_flush !== 1'b1 || pc_out !== 16'h0036) begin
            errs++; $display("FAIL stall release: got flush %b pc %h want 1 0036", obs_flush, pc_out);
        end
    endtask

    task automatic test_wrap();
        redirect_to(16'hFFFE);
        vecs++;
        if (pc_plus2 !== 16'h0000) begin
            errs++; $display("FAIL wrap plus2: got %h want 0000", pc_plus2);
        end
        cycle();
        vecs++;
        if (pc_out !== 16'h0000) begin
            errs++; $display("FAIL wrap pc: got %h want 0000", pc_out);
        end
        d_is_br = 1; d_pc = 16'hFFFC; d_cond = 3'b111; d_imm = 9'd4; d_pred_taken = 0;
        cycle();
        set_idle();
        vecs++;
        if (pc_out !== 16'h0006) begin
            errs++; $display("FAIL wrap tgt: got %h want 0006", pc_out);
        end
    endtask

    task automatic test_both();
        set_idle();
        d_is_br = 1; d_is_br_reg = 1; d_cond = 3'b111; d_reg_addr = 16'h0ABC;
        d_pc = 16'h0100; d_imm = 9'd4;
        cycle();
        set_idle();
        vecs++;
        if (pc_out !== 16'h0ABC) begin
            errs++; $display("FAIL both: got %h want 0abc", pc_out);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 39) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            f_is_br      = $urandom_range(0, 1);
            f_is_hlt     = ($urandom_range(0, 15) == 0);
            f_imm        = 9'($urandom);
            d_is_br      = ($urandom_range(0, 2) == 0);
            d_is_br_reg  = ($urandom_range(0, 7) == 0);
            d_cond       = 3'($urandom);
            d_imm        = 9'($urandom);
            d_reg_addr   = 16'($urandom) & 16'hFFFE;
            d_pc         = 16'($urandom) & 16'hFFFE;
            d_pred_taken = $urandom_range(0, 1);
            flags        = 3'($urandom);
            cycle();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_sequential();
        test_b_eq();
        test_b_gt();
        test_br_hlt();
        test_hlt();
        test_stall();
        test_wrap();
        test_both();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
